// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush/interrupt controller: load-use stall, branch flush, interrupt drain then vector.
// Zero latency: every output is combinational from state and inputs; a hazard stalls PC and IF/ID.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs1,
  input  logic [2:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             int_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       pc_sel,
  output logic             int_ack,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, INT_DRAIN, INT_VEC} state_t;

  state_t           state_q, state_d;
  logic             int_pend_q, int_pend_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;

  assign hazard = id_valid & ex_mem_read &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    int_pend_d  = int_pend_q | int_req;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    pc_sel      = 2'b00;
    int_ack     = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_sel      = 2'b01;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end else if (hazard) begin
          if_id_flush = 1'b0;
          if (stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b0;
          if (int_pend_q) begin
            state_d     = INT_DRAIN;
            drain_cnt_d = 3'(DRAIN_CYCLES);
          end
        end
      end
      INT_DRAIN: begin
        if_id_write = 1'b1;
        drain_cnt_d = drain_cnt_q - 3'd1;
        if (drain_cnt_q == 3'd1) state_d = INT_VEC;
      end
      INT_VEC: begin
        pc_sel      = 2'b10;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        int_ack     = 1'b1;
        state_d     = RUN;
        // A request still high here must be seen again on a later edge to re-arm.
        int_pend_d  = 1'b0;
      end
      default: state_d = RUN;
    endcase
    if (!rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_sel      = 2'b00;
      int_ack     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      int_pend_q  <= 1'b0;
      drain_cnt_q <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      int_pend_q  <= int_pend_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level interrupt-sequence model.
module tb_pipeline_ctrl;
  localparam int DRAIN = 2;
  localparam int CW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, int_req;
  logic [2:0]    id_rs1, id_rs2, ex_rd;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, int_ack;
  logic [1:0]    pc_sel;
  logic [CW-1:0] stall_cnt;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .int_req(int_req), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_sel(pc_sel), .int_ack(int_ack), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_left counts the remaining cycles of an interrupt sequence
  // (DRAIN drain cycles followed by the vector cycle); zero means normal running.
  bit m_pend;
  int m_left;
  int m_stalls;
  int ack_seen;

  task automatic step(input logic r, input logic iv, input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic u1, input logic u2, input logic mr, input logic [2:0] rd,
                      input logic br, input logic ir);
    logic hz, e_pw, e_iw, e_iff, e_ief, e_ack;
    logic [1:0] e_sel;
    @(negedge clk);
    rst = r; id_valid = iv; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; branch_taken = br; int_req = ir;
    #1;
    hz = iv && mr && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e_pw = 0; e_iw = 0; e_iff = 1; e_ief = 1; e_sel = 2'b00; e_ack = 0;
    if (!r) begin
      m_pend = 0; m_left = 0; m_stalls = 0;
    end else if (m_left == 1) begin
      e_pw = 1; e_iw = 1; e_sel = 2'b10; e_ack = 1;
    end else if (m_left > 1) begin
      e_iw = 1;
    end else if (br) begin
      e_pw = 1; e_iw = 1; e_sel = 2'b01;
    end else if (hz) begin
      e_iff = 0;
    end else begin
      e_pw = 1; e_iw = 1; e_iff = 0; e_ief = 0;
    end
    check("pc_write", 32'(pc_write), 32'(e_pw));
    check("if_id_write", 32'(if_id_write), 32'(e_iw));
    check("if_id_flush", 32'(if_id_flush), 32'(e_iff));
    check("id_ex_flush", 32'(id_ex_flush), 32'(e_ief));
    check("pc_sel", 32'(pc_sel), 32'(e_sel));
    check("int_ack", 32'(int_ack), 32'(e_ack));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    if (int_ack) ack_seen++;
    if (r) begin
      if (m_left == 0 && !br && hz) m_stalls = (m_stalls < (1 << CW) - 1) ? m_stalls + 1 : m_stalls;
      if (m_left > 0) begin
        if (m_left == 1) m_pend = 0;
        else m_pend = m_pend | ir;
        m_left = m_left - 1;
      end else begin
        if (m_pend && !br && !hz) m_left = DRAIN + 1;
        m_pend = m_pend | ir;
      end
    end
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(r, 1, 3'd1, 3'd2, 1, 1, 0, 3'd0, 0, 0);
  endtask

  task automatic load_use();
    step(1, 1, 3'd0, 3'd3, 0, 1, 1, 3'd3, 0, 0);
  endtask

  int acks0;

  initial begin
    rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; branch_taken = 0; int_req = 0;
    m_pend = 0; m_left = 0; m_stalls = 0; ack_seen = 0;
    idle(2, 0);
    idle(2, 1);

    // Load-use stall: counter 0 -> 1.
    load_use();
    idle(1, 1);
    check("load_use_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch together with hazard: branch wins, no stall counted.
    step(1, 1, 3'd0, 3'd3, 0, 1, 1, 3'd3, 1, 0);
    check("branch_hazard_sel", 32'(pc_sel), 32'd1);
    idle(1, 1);
    check("branch_hazard_stall_cnt", 32'(stall_cnt), 32'd1);

    // Interrupt pulse in RUN: one ack, drain cycles hold the PC.
    acks0 = ack_seen;
    step(1, 1, 3'd1, 3'd2, 1, 1, 0, 3'd0, 0, 1);
    idle(1, 1);
    step(1, 1, 3'd1, 3'd2, 1, 1, 0, 3'd0, 0, 0);
    check("drain1_pc_write", 32'(pc_write), 32'd0);
    step(1, 1, 3'd1, 3'd2, 1, 1, 0, 3'd0, 0, 0);
    check("drain2_pc_write", 32'(pc_write), 32'd0);
    step(1, 1, 3'd1, 3'd2, 1, 1, 0, 3'd0, 0, 0);
    check("vector_sel", 32'(pc_sel), 32'd2);
    check("vector_ack", 32'(int_ack), 32'd1);
    idle(4, 1);
    check("int_pulse_ack_count", 32'(ack_seen - acks0), 32'd1);

    // Interrupt arriving during a multi-cycle hazard waits for it to clear.
    acks0 = ack_seen;
    step(1, 1, 3'd0, 3'd3, 0, 1, 1, 3'd3, 0, 1);
    load_use();
    load_use();
    check("int_during_hazard_held", 32'(pc_write), 32'd0);
    idle(8, 1);
    check("int_during_hazard_acks", 32'(ack_seen - acks0), 32'd1);

    // Reset in INT_DRAIN abandons the interrupt.
    acks0 = ack_seen;
    step(1, 1, 3'd1, 3'd2, 1, 1, 0, 3'd0, 0, 1);
    idle(2, 1);
    check("pre_reset_in_drain", 32'(if_id_flush & ~pc_write), 32'd1);
    idle(2, 0);
    check("reset_int_pend", 32'(dut.int_pend_q), 32'd0);
    idle(6, 1);
    check("reset_drain_no_ack", 32'(ack_seen - acks0), 32'd0);

    // Saturation of the 4-bit stall counter.
    idle(1, 0);
    for (int i = 0; i < 20; i++) load_use();
    idle(1, 1);
    check("stall_saturation", 32'(stall_cnt), 32'd15);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 79) != 0), 1'($urandom), 3'($urandom_range(0, 3)),
           3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
